// File: rtl/poly_add_pe.sv
// poly_add_pe: coefficient-wise modular add/subtract engine for two
// N-entry polynomials. It speaks the same serial load/start/read/done
// protocol as the NTT core, so existing serializer/deserializer logic
// can drive it unchanged.
//
// Ports
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset
//   load_a_f    pulse: capture the next N din words into memory A
//   load_b_f    pulse: capture the next N din words into memory B
//   start_add   pulse: A[i] := (A[i] + B[i]) mod Q for all i
//   start_sub   pulse: A[i] := (A[i] - B[i]) mod Q for all i
//   read_a      pulse: stream memory A out on dout
//   din         serial coefficient input
//   dout        serial coefficient output (0 when dout_valid is low)
//   dout_valid  dout carries a coefficient
//   done        one-cycle pulse at the end of an add/sub pass
//   busy        engine is not idle; commands are only taken while idle
module poly_add_pe #(
   parameter int N = 256,
   parameter int W = 12,
   parameter int Q = 3329
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         load_a_f,
   input  logic         load_b_f,
   input  logic         start_add,
   input  logic         start_sub,
   input  logic         read_a,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         dout_valid,
   output logic         done,
   output logic         busy
);

   localparam int AW = $clog2(N);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] CNT_ZERO       = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE        = CW'(1);
   localparam logic [CW-1:0] CNT_LOAD_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] CNT_N          = CW'(N);
   // ARITH runs two extra cycles to drain the read and arithmetic stages.
   localparam logic [CW-1:0] CNT_ARITH_LAST = CW'(N + 1);
   localparam logic [W:0]    Q_WIDE         = (W+1)'(Q);
   localparam logic [W-1:0]  Q_NARROW       = W'(Q);
   localparam logic [W-1:0]  COEF_ZERO      = {W{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_ARITH  = 3'd3,
      S_READ_A = 3'd4
   } state_t;

   // Single conditional subtraction is enough because 2^W < 2Q.
   function automatic logic [W-1:0] reduce_once(input logic [W-1:0] v);
      if ({1'b0, v} >= Q_WIDE) begin
         return v - Q_NARROW;
      end else begin
         return v;
      end
   endfunction

   // Operands are always already reduced to [0, Q-1].
   function automatic logic [W-1:0] mod_addsub(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic         sub);
      logic [W:0] sum;
      if (sub) begin
         if (a >= b) begin
            return a - b;
         end else begin
            return a + (Q_NARROW - b);
         end
      end else begin
         sum = {1'b0, a} + {1'b0, b};
         if (sum >= Q_WIDE) begin
            sum = sum - Q_WIDE;
         end else begin
            sum = sum;
         end
         return sum[W-1:0];
      end
   endfunction

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic            sub_r, sub_s;
   logic            done_s;

   logic [W-1:0]    mem_a_r [N];
   logic [W-1:0]    mem_b_r [N];
   logic [W-1:0]    rd_a_r, rd_b_r;
   logic            vld1_r, vld2_r;
   logic [AW-1:0]   idx1_r, idx2_r;
   logic [W-1:0]    res_r;
   logic [W-1:0]    dout_r;
   logic            dout_valid_r, done_r, busy_r;

   logic [AW-1:0]   raddr_s;
   logic            arith_rd_s, read_out_s;
   logic            we_a_s, we_b_s;
   logic [AW-1:0]   wa_a_s;
   logic [W-1:0]    wd_a_s;

   assign raddr_s    = cnt_r[AW-1:0];
   assign arith_rd_s = (state_r == S_ARITH)  && (cnt_r < CNT_N);
   assign read_out_s = (state_r == S_READ_A) && (cnt_r < CNT_N);

   // Next-state logic: commands are only honoured in IDLE, in fixed priority.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + CNT_ONE;
      sub_s   = sub_r;
      done_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            cnt_s = CNT_ZERO;
            if (load_a_f) begin
               state_s = S_LOAD_A;
            end else if (load_b_f) begin
               state_s = S_LOAD_B;
            end else if (start_add) begin
               state_s = S_ARITH;
               sub_s   = 1'b0;
            end else if (start_sub) begin
               state_s = S_ARITH;
               sub_s   = 1'b1;
            end else if (read_a) begin
               state_s = S_READ_A;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            if (cnt_r == CNT_LOAD_LAST) begin
               state_s = S_IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = state_r;
            end
         end
         S_ARITH: begin
            if (cnt_r == CNT_ARITH_LAST) begin
               state_s = S_IDLE;
               cnt_s   = CNT_ZERO;
               done_s  = 1'b1;
            end else begin
               state_s = S_ARITH;
            end
         end
         S_READ_A: begin
            if (cnt_r == CNT_N) begin
               state_s = S_IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = S_READ_A;
            end
         end
         default: begin
            state_s = S_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Write-port steering: loads and the arithmetic write-back never overlap.
   always_comb begin
      we_a_s = 1'b0;
      wa_a_s = {AW{1'b0}};
      wd_a_s = COEF_ZERO;
      we_b_s = (state_r == S_LOAD_B);
      if (state_r == S_LOAD_A) begin
         we_a_s = 1'b1;
         wa_a_s = raddr_s;
         wd_a_s = reduce_once(din);
      end else if (vld2_r) begin
         we_a_s = 1'b1;
         wa_a_s = idx2_r;
         wd_a_s = res_r;
      end else begin
         we_a_s = 1'b0;
      end
   end

   // FSM state, shared operation counter and latched add/sub selector.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= S_IDLE;
         cnt_r   <= CNT_ZERO;
         sub_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         sub_r   <= sub_s;
      end
   end

   // Arithmetic pipeline (read -> compute -> write back) and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld1_r       <= 1'b0;
         vld2_r       <= 1'b0;
         idx1_r       <= {AW{1'b0}};
         idx2_r       <= {AW{1'b0}};
         res_r        <= COEF_ZERO;
         dout_r       <= COEF_ZERO;
         dout_valid_r <= 1'b0;
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         vld1_r       <= arith_rd_s;
         idx1_r       <= raddr_s;
         vld2_r       <= vld1_r;
         idx2_r       <= idx1_r;
         res_r        <= mod_addsub(rd_a_r, rd_b_r, sub_r);
         dout_r       <= read_out_s ? mem_a_r[raddr_s] : COEF_ZERO;
         dout_valid_r <= read_out_s;
         done_r       <= done_s;
         busy_r       <= (state_s != S_IDLE);
      end
   end

   // Coefficient memories: no reset so they map onto RAM primitives.
   always_ff @(posedge clk_i) begin
      if (we_a_s) begin
         mem_a_r[wa_a_s] <= wd_a_s;
      end
      if (we_b_s) begin
         mem_b_r[raddr_s] <= reduce_once(din);
      end
      rd_a_r <= mem_a_r[raddr_s];
      rd_b_r <= mem_b_r[raddr_s];
   end

   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;
   assign done       = done_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_poly_add_pe.sv
// Testbench for poly_add_pe: directed sequence with random data, checked
// against an array-based reference model using plain modular arithmetic.
module tb_poly_add_pe;

   localparam int N = 256;
   localparam int W = 12;
   localparam int Q = 3329;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         load_a_f  = 1'b0;
   logic         load_b_f  = 1'b0;
   logic         start_add = 1'b0;
   logic         start_sub = 1'b0;
   logic         read_a    = 1'b0;
   logic [W-1:0] din       = '0;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         done;
   logic         busy;

   int model_a [N];
   int model_b [N];
   int stim    [N];
   int passed = 0;
   int total  = 0;

   poly_add_pe #(.N(N), .W(W), .Q(Q)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .load_a_f   (load_a_f),
      .load_b_f   (load_b_f),
      .start_add  (start_add),
      .start_sub  (start_sub),
      .read_a     (read_a),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int capture(input int v);
      return v % Q;
   endfunction

   // Load the stim[] table into A or B; optionally also pulse start_add with
   // the load command and again in the middle of the load.
   task automatic do_load(input bit to_b, input bit extra_cmd);
      @(negedge clk);
      if (to_b) load_b_f = 1'b1; else load_a_f = 1'b1;
      start_add = extra_cmd;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         load_a_f  = 1'b0;
         load_b_f  = 1'b0;
         start_add = extra_cmd && (k == 10);
         din       = W'(stim[k]);
         check("load_busy", 32'(busy), 32'd1);
         check("load_done", 32'(done), 32'd0);
         if (to_b) model_b[k] = capture(stim[k]);
         else      model_a[k] = capture(stim[k]);
      end
      @(negedge clk);
      start_add = 1'b0;
      din       = '0;
      check("load_end_busy", 32'(busy), 32'd0);
      check("load_end_done", 32'(done), 32'd0);
   endtask

   // Add or subtract; when b2b is set a read_a pulse is given in the last busy
   // cycle (must be ignored) and held into the next cycle (must be accepted).
   task automatic do_arith(input bit sub, input bit b2b);
      @(negedge clk);
      if (sub) start_sub = 1'b1; else start_add = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (sub) model_a[k] = (model_a[k] - model_b[k] + Q) % Q;
         else     model_a[k] = (model_a[k] + model_b[k]) % Q;
      end
      for (int c = 1; c <= N + 3; c++) begin
         @(negedge clk);
         start_add = 1'b0;
         start_sub = 1'b0;
         if (c < N + 3) begin
            check("arith_busy", 32'(busy), 32'd1);
            check("arith_done_early", 32'(done), 32'd0);
         end else begin
            check("arith_done", 32'(done), 32'd1);
            check("arith_busy_end", 32'(busy), 32'd0);
         end
         if (b2b && (c >= N + 2)) read_a = 1'b1;
      end
   endtask

   // Stream A out and compare every coefficient with the model.
   task automatic do_read(input bit pre_pulsed);
      if (!pre_pulsed) begin
         @(negedge clk);
         read_a = 1'b1;
      end
      @(negedge clk);
      read_a = 1'b0;
      check("read_busy_first", 32'(busy), 32'd1);
      check("read_valid_first", 32'(dout_valid), 32'd0);
      check("read_dout_idle", 32'(dout), 32'd0);
      check("read_done", 32'(done), 32'd0);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         check("read_valid", 32'(dout_valid), 32'd1);
         check("read_data", 32'(dout), 32'(model_a[k]));
         if (k == N - 1) check("read_busy_last", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("read_valid_end", 32'(dout_valid), 32'd0);
      check("read_dout_end", 32'(dout), 32'd0);
      check("read_busy_end", 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_valid", 32'(dout_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // A=k, B=2k, add -> 3k mod Q
      for (int k = 0; k < N; k++) stim[k] = k;
      do_load(1'b0, 1'b0);
      for (int k = 0; k < N; k++) stim[k] = 2 * k;
      do_load(1'b1, 1'b0);
      do_arith(1'b0, 1'b0);
      do_read(1'b0);

      // A=5, B=7, sub -> 3327; then B=3327, add -> 3325
      for (int k = 0; k < N; k++) stim[k] = 5;
      do_load(1'b0, 1'b0);
      for (int k = 0; k < N; k++) stim[k] = 7;
      do_load(1'b1, 1'b0);
      do_arith(1'b1, 1'b0);
      do_read(1'b0);
      for (int k = 0; k < N; k++) stim[k] = 3327;
      do_load(1'b1, 1'b0);
      do_arith(1'b0, 1'b0);
      do_read(1'b0);

      // Out-of-range capture: 4095 -> 766, 3329 -> 0
      for (int k = 0; k < N; k++) stim[k] = (k % 2 == 0) ? 4095 : 3329;
      do_load(1'b0, 1'b0);
      do_read(1'b0);

      // Load wins over a simultaneous start_add; start_add during load ignored
      for (int k = 0; k < N; k++) stim[k] = int'($urandom_range(0, 4095));
      do_load(1'b0, 1'b1);
      do_read(1'b0);

      // Random add/sub rounds, the last one with a back-to-back read
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < N; k++) stim[k] = int'($urandom_range(0, 4095));
         do_load(1'b0, 1'b0);
         for (int k = 0; k < N; k++) stim[k] = int'($urandom_range(0, 4095));
         do_load(1'b1, 1'b0);
         do_arith(1'($urandom_range(0, 1)), r == 3);
         do_read(r == 3);
      end

      // Asynchronous reset during ARITH at index 100
      @(negedge clk);
      start_sub = 1'b1;
      for (int c = 1; c <= 101; c++) begin
         @(negedge clk);
         start_sub = 1'b0;
      end
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_dout", 32'(dout), 32'd0);
      check("async_rst_valid", 32'(dout_valid), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      for (int k = 0; k < N; k++) stim[k] = int'($urandom_range(0, 4095));
      do_load(1'b0, 1'b0);
      do_read(1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
